// File: rtl/clk_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : clk_rst_seq
// Description : Reset sequencer and clock-enable generator on the PLL fast
//               clock. It synchronises the release of the board-level async
//               reset, holds the system reset for a fixed settle time, and
//               then issues a periodic one-cycle clock-enable with its phase.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_rst_seq #(
   parameter int SYNC_STAGES = 2,     // reset-release synchronizer depth (>=2)
   parameter int HOLD_CYCLES = 1024,  // settle cycles after sync release (>=1)
   parameter int CNT_W       = 16,    // hold counter width, 2**CNT_W >= HOLD_CYCLES
   parameter int CE_DIV      = 7,     // clock-enable period in clk cycles (>=1)
   parameter int PH_W        = 3      // ce_phase width, max(1, $clog2(CE_DIV))
) (
   input  logic            clk,        // PLL fast clock
   input  logic            rst_n,      // async active-low board reset
   input  logic            soft_rst,   // sync active-high restart request
   output logic            sys_rst_n,  // registered system reset, active-low
   output logic            ce,         // one-cycle enable every CE_DIV cycles
   output logic [PH_W-1:0] ce_phase,   // position within the CE period
   output logic            ready       // set once the first ce has been issued
);

   // Two-state sequencer: HOLD keeps everything in reset, RUN generates ce.
   typedef enum logic [0:0] {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Terminal values for the hold counter and the phase counter.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CE_DIV - 1);
   localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
   // With a divide of 1 the enable is asserted on every RUN cycle,
   // including the very first one.
   localparam logic             CE_EVERY = (CE_DIV == 1);

   // Synchronizer chain
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   sync_ok;

   // Sequencer state and hold counter
   state_t                 state_q;
   state_t                 state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;

   // Registered outputs
   logic                   sys_rst_n_q;
   logic                   sys_rst_n_d;
   logic                   ce_q;
   logic                   ce_d;
   logic [PH_W-1:0]        ce_phase_q;
   logic [PH_W-1:0]        ce_phase_d;
   logic                   ready_q;
   logic                   ready_d;

   // Release synchronizer: shift a constant 1 in; the last stage qualifies
   // the hold counter. It is only cleared by rst_n, never by soft_rst, so a
   // soft restart does not repeat the synchronisation delay.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   assign sync_ok = sync_q[SYNC_STAGES-1];

   // Synchronizer flops with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   // Next-state and next-output logic. Every output is computed here and
   // registered below, so no input reaches an output combinationally.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sys_rst_n_d = 1'b0;
      ce_d        = 1'b0;
      ce_phase_d  = '0;
      ready_d     = 1'b0;

      if (soft_rst) begin
         // Restart request dominates everything, including the HOLD
         // terminal count; outputs fall back to their reset values.
         state_d = ST_HOLD;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               // Count only once the synchronizer has released; the
               // terminal compare is qualified too so that a short hold
               // never bypasses synchronisation.
               if (sync_ok) begin
                  if (cnt_q == CNT_LAST) begin
                     state_d     = ST_RUN;
                     cnt_d       = '0;
                     sys_rst_n_d = 1'b1;
                     ce_phase_d  = '0;
                     ce_d        = CE_EVERY;
                     ready_d     = CE_EVERY;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end

            ST_RUN: begin
               sys_rst_n_d = 1'b1;
               if (ce_phase_q == PH_LAST) begin
                  ce_phase_d = '0;
               end else begin
                  ce_phase_d = ce_phase_q + PH_ONE;
               end
               ce_d    = (ce_phase_d == PH_LAST);
               ready_d = ready_q | ce_d;
            end

            default: begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State, counter and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_HOLD;
         cnt_q       <= '0;
         sys_rst_n_q <= 1'b0;
         ce_q        <= 1'b0;
         ce_phase_q  <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sys_rst_n_q <= sys_rst_n_d;
         ce_q        <= ce_d;
         ce_phase_q  <= ce_phase_d;
         ready_q     <= ready_d;
      end
   end

   assign sys_rst_n = sys_rst_n_q;
   assign ce        = ce_q;
   assign ce_phase  = ce_phase_q;
   assign ready     = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_rst_seq
// Description : Self-checking bench for clk_rst_seq. Instance A uses the
//               CE_DIV=7 configuration, instance B the CE_DIV=1 corner case.
//               Expected reset-release and ce events are queued with their
//               cycle numbers and matched against what the DUT emits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_rst_seq;

   localparam int SYNC = 2;
   localparam int HOLD = 16;

   logic       clk;
   logic       rst_n;
   logic       soft_rst;

   logic       a_sys_rst_n;
   logic       a_ce;
   logic [2:0] a_ce_phase;
   logic       a_ready;

   logic       b_sys_rst_n;
   logic       b_ce;
   logic [0:0] b_ce_phase;
   logic       b_ready;

   int         cyc;
   int         n_tot;
   int         n_bad;
   logic       mon_en;
   logic       prev_rst;

   // Expected event: kind 0 = sys_rst_n rise, kind 1 = ce pulse.
   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   ev_t exp_q[$];

   clk_rst_seq #(
      .SYNC_STAGES (SYNC),
      .HOLD_CYCLES (HOLD),
      .CNT_W       (5),
      .CE_DIV      (7),
      .PH_W        (3)
   ) u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .soft_rst  (soft_rst),
      .sys_rst_n (a_sys_rst_n),
      .ce        (a_ce),
      .ce_phase  (a_ce_phase),
      .ready     (a_ready)
   );

   clk_rst_seq #(
      .SYNC_STAGES (SYNC),
      .HOLD_CYCLES (HOLD),
      .CNT_W       (16),
      .CE_DIV      (1),
      .PH_W        (1)
   ) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .soft_rst  (soft_rst),
      .sys_rst_n (b_sys_rst_n),
      .ce        (b_ce),
      .ce_phase  (b_ce_phase),
      .ready     (b_ready)
   );

   // 100 MHz bench clock; posedges at 5, 15, 25 ... ns.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Posedge counter, read only at negedges.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input longint obs, input longint exp);
      n_tot++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input int at);
      ev_t ev;
      ev.kind = kind;
      ev.cyc  = at;
      exp_q.push_back(ev);
   endtask

   task automatic sb_pop(input int kind);
      ev_t ev;
      if (exp_q.size() == 0) begin
         chk_eq("sb_extra_event", kind, -1);
      end else begin
         ev = exp_q.pop_front();
         chk_eq("sb_kind", kind, ev.kind);
         chk_eq((kind == 0) ? "sb_rise_cycle" : "sb_ce_cycle", cyc, ev.cyc);
      end
   endtask

   task automatic sb_drain(input string tag);
      chk_eq(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Output monitor for instance A: turns rises of sys_rst_n and ce pulses
   // into events matched against the expected queue.
   initial prev_rst = 1'b0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (a_sys_rst_n && !prev_rst) sb_pop(0);
         if (a_ce) sb_pop(1);
      end
      prev_rst = a_sys_rst_n;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int lst;
      int g;
      n_tot    = 0;
      n_bad    = 0;
      mon_en   = 1'b0;
      rst_n    = 1'b1;
      soft_rst = 1'b0;

      // Power-up: reset values while rst_n is low.
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk_eq("rst_sys_rst_n", a_sys_rst_n, 0);
      chk_eq("rst_ce", a_ce, 0);
      chk_eq("rst_ce_phase", a_ce_phase, 0);
      chk_eq("rst_ready", a_ready, 0);
      chk_eq("rst_b_sys_rst_n", b_sys_rst_n, 0);
      chk_eq("rst_b_ce", b_ce, 0);
      repeat (4) @(negedge clk);

      // Release: sys_rst_n after edge 18, ce at 24, 31, 38.
      rst_n  = 1'b1;
      base   = cyc;
      mon_en = 1'b1;
      push_ev(0, base + 18);
      push_ev(1, base + 24);
      push_ev(1, base + 31);
      push_ev(1, base + 38);
      wait_to(base + 17);
      chk_eq("pu_sys_rst_n_e17", a_sys_rst_n, 0);
      chk_eq("pu_b_sys_rst_n_e17", b_sys_rst_n, 0);
      chk_eq("pu_b_ce_e17", b_ce, 0);
      for (int k = 0; k < 22; k++) begin
         wait_to(base + 18 + k);
         chk_eq("pu_sys_rst_n", a_sys_rst_n, 1);
         chk_eq("pu_ce_phase", a_ce_phase, k % 7);
         chk_eq("pu_ready", a_ready, (k >= 6) ? 1 : 0);
         if (k < 8) begin
            chk_eq("div1_ce", b_ce, 1);
            chk_eq("div1_ready", b_ready, 1);
            chk_eq("div1_ce_phase", b_ce_phase, 0);
         end
      end
      wait_to(base + 40);
      mon_en = 1'b0;
      sb_drain("pu_sb_left");

      // Async reset mid-RUN, dropped between clock edges.
      wait_to(base + 42);
      chk_eq("ar_phase_before", a_ce_phase, 3);
      #2 rst_n = 1'b0;
      #1;
      chk_eq("ar_sys_rst_n", a_sys_rst_n, 0);
      chk_eq("ar_ce_phase", a_ce_phase, 0);
      chk_eq("ar_ready", a_ready, 0);
      chk_eq("ar_b_ce", b_ce, 0);
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      base   = cyc;
      mon_en = 1'b1;
      // Same 18-cycle timing, then a soft_rst pulse sampled at edge +28.
      push_ev(0, base + 18);
      push_ev(1, base + 24);
      push_ev(0, base + 44);
      push_ev(1, base + 50);
      wait_to(base + 17);
      chk_eq("ar_sys_rst_n_e17", a_sys_rst_n, 0);
      wait_to(base + 18);
      chk_eq("ar_sys_rst_n_e18", a_sys_rst_n, 1);
      chk_eq("ar_ce_phase_e18", a_ce_phase, 0);
      wait_to(base + 27);
      soft_rst = 1'b1;
      wait_to(base + 28);
      soft_rst = 1'b0;
      chk_eq("sr_sys_rst_n", a_sys_rst_n, 0);
      chk_eq("sr_ce", a_ce, 0);
      chk_eq("sr_ready", a_ready, 0);
      chk_eq("sr_ce_phase", a_ce_phase, 0);
      wait_to(base + 43);
      chk_eq("sr_sys_rst_n_e15", a_sys_rst_n, 0);
      wait_to(base + 44);
      chk_eq("sr_sys_rst_n_e16", a_sys_rst_n, 1);
      chk_eq("sr_ce_phase_e16", a_ce_phase, 0);
      wait_to(base + 45);
      chk_eq("sr_ce_phase_e17", a_ce_phase, 1);
      wait_to(base + 52);
      mon_en = 1'b0;
      sb_drain("sr_sb_left");

      // soft_rst held three cycles across the HOLD terminal count.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      base   = cyc;
      lst    = base + 20;
      mon_en = 1'b1;
      push_ev(0, lst + 16);
      push_ev(1, lst + 22);
      wait_to(base + 17);
      soft_rst = 1'b1;
      wait_to(base + 18);
      chk_eq("st_sys_rst_n_term", a_sys_rst_n, 0);
      wait_to(lst);
      soft_rst = 1'b0;
      chk_eq("st_sys_rst_n_held", a_sys_rst_n, 0);
      wait_to(lst + 15);
      chk_eq("st_sys_rst_n_e15", a_sys_rst_n, 0);
      wait_to(lst + 16);
      chk_eq("st_sys_rst_n_e16", a_sys_rst_n, 1);
      wait_to(lst + 24);
      mon_en = 1'b0;
      sb_drain("st_sb_left");

      // Sub-cycle rst_n glitch during HOLD restarts the full sequence.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      base   = cyc;
      g      = base + 10;
      mon_en = 1'b1;
      push_ev(0, g + 18);
      push_ev(1, g + 24);
      wait_to(g);
      #1 rst_n = 1'b0;
      #3 rst_n = 1'b1;
      wait_to(base + 18);
      chk_eq("gl_sys_rst_n_orig", a_sys_rst_n, 0);
      wait_to(g + 17);
      chk_eq("gl_sys_rst_n_e17", a_sys_rst_n, 0);
      wait_to(g + 18);
      chk_eq("gl_sys_rst_n_e18", a_sys_rst_n, 1);
      wait_to(g + 26);
      mon_en = 1'b0;
      sb_drain("gl_sb_left");

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
